// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the 8x8 multiplier built from one 4x4 multiplier.
// It clears the accumulator, then accumulates the four shifted nibble partial products.
module mult_seq_ctrl #(
    parameter bit ERR_ON_RESTART = 1'b1
) (
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done,
    output logic       err,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_CLR  = 3'b001,
        S_LSB  = 3'b010,
        S_MID0 = 3'b011,
        S_MID1 = 3'b100,
        S_MSB  = 3'b101,
        S_DONE = 3'b110,
        S_ERR  = 3'b111
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] shift_q, shift_d;
    logic       ena_q, ena_d;
    logic       sclr_n_q, sclr_n_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic restart_err;
    assign restart_err = ERR_ON_RESTART && start;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = start ? S_CLR : S_IDLE;
            S_CLR:  state_d = restart_err ? S_ERR : S_LSB;
            S_LSB:  state_d = restart_err ? S_ERR : S_MID0;
            S_MID0: state_d = restart_err ? S_ERR : S_MID1;
            S_MID1: state_d = restart_err ? S_ERR : S_MSB;
            S_MSB:  state_d = restart_err ? S_ERR : S_DONE;
            S_DONE: state_d = start ? S_CLR : S_IDLE;
            S_ERR:  state_d = start ? S_ERR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they always
    // match the decode of the current state and reset straight to IDLE values.
    always_comb begin
        sel_d    = 2'b00;
        shift_d  = 2'b00;
        ena_d    = 1'b0;
        sclr_n_d = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_d)
            S_CLR: begin
                ena_d    = 1'b1;
                sclr_n_d = 1'b0;
            end
            S_LSB: ena_d = 1'b1;
            S_MID0: begin
                ena_d   = 1'b1;
                sel_d   = 2'b01;
                shift_d = 2'b01;
            end
            S_MID1: begin
                ena_d   = 1'b1;
                sel_d   = 2'b10;
                shift_d = 2'b01;
            end
            S_MSB: begin
                ena_d   = 1'b1;
                sel_d   = 2'b11;
                shift_d = 2'b10;
            end
            S_DONE: done_d = 1'b1;
            S_ERR:  err_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 2'b00;
            shift_q  <= 2'b00;
            ena_q    <= 1'b0;
            sclr_n_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shift_q  <= shift_d;
            ena_q    <= ena_d;
            sclr_n_q <= sclr_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign input_sel = sel_q;
    assign shift_sel = shift_q;
    assign clk_ena   = ena_q;
    assign sclr_n    = sclr_n_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: two instances (restart-error on/off), each driving a
// model multiplier datapath whose accumulator is compared against plain A*B.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic aclr_n = 1'b0;
    logic start1 = 1'b0, start0 = 1'b0;

    logic [1:0] sel1, shift1, sel0, shift0;
    logic       ena1, sclr1, done1, err1, ena0, sclr0, done0, err0;
    logic [2:0] st1, st0;

    logic [7:0]  a1 = 8'h00, b1 = 8'h00, a0 = 8'h00, b0 = 8'h00;
    logic [15:0] acc1, acc0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.ERR_ON_RESTART(1'b1)) dut1 (
        .clk(clk), .aclr_n(aclr_n), .start(start1),
        .input_sel(sel1), .shift_sel(shift1), .clk_ena(ena1), .sclr_n(sclr1),
        .done(done1), .err(err1), .state_out(st1)
    );

    mult_seq_ctrl #(.ERR_ON_RESTART(1'b0)) dut0 (
        .clk(clk), .aclr_n(aclr_n), .start(start0),
        .input_sel(sel0), .shift_sel(shift0), .clk_ena(ena0), .sclr_n(sclr0),
        .done(done0), .err(err0), .state_out(st0)
    );

    function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] sel, input logic [1:0] sh);
        int pa, pb, amt;
        pa  = sel[1] ? int'(a[7:4]) : int'(a[3:0]);
        pb  = sel[0] ? int'(b[7:4]) : int'(b[3:0]);
        amt = (sh == 2'b00) ? 0 : (sh == 2'b01) ? 4 : (sh == 2'b10) ? 8 : 12;
        return 16'((pa * pb) << amt);
    endfunction

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            acc1 <= 16'h0;
            acc0 <= 16'h0;
        end else begin
            if (ena1) acc1 <= !sclr1 ? 16'h0 : acc1 + partial(a1, b1, sel1, shift1);
            if (ena0) acc0 <= !sclr0 ? 16'h0 : acc0 + partial(a0, b0, sel0, shift0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle1(input string tag);
        check({tag, " state"}, 32'(st1), 32'd0);
        check({tag, " ena"}, 32'(ena1), 32'd0);
        check({tag, " sclr_n"}, 32'(sclr1), 32'd1);
        check({tag, " done"}, 32'(done1), 32'd0);
        check({tag, " err"}, 32'(err1), 32'd0);
    endtask

    // Pulse start on dut1 and wait for done; product must equal a*b, 6 edges after start.
    task automatic run_product1(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        a1 = a; b1 = b;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 12) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd6);
        check({tag, " product"}, 32'(acc1), 32'(int'(a) * int'(b)));
    endtask

    initial begin
        logic [2:0] exp_st[6]    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [1:0] exp_sel[6]   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_shift[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        logic       exp_sclr[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_ena[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_done[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int n;

        #23;
        check_idle1("reset");
        check("reset st0", 32'(st0), 32'd0);
        aclr_n = 1'b1;
        tick();
        check_idle1("post-reset idle");

        // Basic sequence, step by step
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq%0d state", i), 32'(st1), 32'(exp_st[i]));
            check($sformatf("seq%0d sel", i), 32'(sel1), 32'(exp_sel[i]));
            check($sformatf("seq%0d shift", i), 32'(shift1), 32'(exp_shift[i]));
            check($sformatf("seq%0d sclr_n", i), 32'(sclr1), 32'(exp_sclr[i]));
            check($sformatf("seq%0d ena", i), 32'(ena1), 32'(exp_ena[i]));
            check($sformatf("seq%0d done", i), 32'(done1), 32'(exp_done[i]));
            if (i < 5) tick();
        end
        tick();
        check_idle1("after done");

        run_product1(8'hFF, 8'hFF, "ffxff");
        run_product1(8'h12, 8'h34, "12x34");
        run_product1(8'h00, 8'hAB, "00xab");

        // Back-to-back restart from DONE
        a1 = 8'h07; b1 = 8'h09;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("b2b state", 32'(st1), 32'd1);
        tick();
        check("b2b cleared", 32'(acc1), 32'd0);
        n = 2;
        while (!done1 && n < 12) begin
            tick();
            n++;
        end
        check("b2b latency", 32'(n), 32'd6);
        check("b2b product", 32'(acc1), 32'h003F);
        tick();

        for (int r = 0; r < 8; r++)
            run_product1(8'($urandom_range(255)), 8'($urandom_range(255)), $sformatf("rand%0d", r));
        tick();

        // Restart mid-operation forces ERR
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("err pre LSB", 32'(st1), 32'd2);
        start1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("err hold%0d state", i), 32'(st1), 32'd7);
            check($sformatf("err hold%0d err", i), 32'(err1), 32'd1);
            check($sformatf("err hold%0d ena", i), 32'(ena1), 32'd0);
            check($sformatf("err hold%0d done", i), 32'(done1), 32'd0);
        end
        start1 = 1'b0;
        tick();
        check_idle1("err exit");

        // Restart ignored when the error option is off
        a0 = 8'hC5; b0 = 8'h3B;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        check("ign MID1", 32'(st0), 32'd4);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("ign MSB", 32'(st0), 32'd5);
        check("ign err", 32'(err0), 32'd0);
        tick();
        check("ign done", 32'(done0), 32'd1);
        check("ign product", 32'(acc0), 32'(int'(8'hC5) * int'(8'h3B)));
        tick();
        check("ign idle", 32'(st0), 32'd0);

        // Asynchronous reset in MID0, observed without a clock edge
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        check("pre-rst MID0", 32'(st1), 32'd3);
        #2;
        aclr_n = 1'b0;
        #1;
        check_idle1("async rst");
        #2;
        aclr_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_idle1("rst idles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
